// File: rtl/lcd_hd44780_driver.sv
// HD44780 write-cycle sequencer driven by a toggle-handshake LCD register word.
// Optional power-on init sequence is built when LCD_AUTO_INIT_EN is defined.
module lcd_hd44780_driver #(
   parameter int T_SETUP_CYC = 3,
   parameter int T_EN_CYC    = 25,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_EXEC_CYC  = 2000,
   parameter int T_CLR_CYC   = 82000,
   parameter int CNT_W       = 17
`ifdef LCD_AUTO_INIT_EN
   ,
   parameter int T_PWR_CYC   = 750000
`endif
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] io_lcd_i,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        busy_o,
   output logic        ack_tgl_o
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      EXEC
`ifdef LCD_AUTO_INIT_EN
      ,
      INIT_WAIT
`endif
   } state_t;

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(T_CLR_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             req;
   logic             pending;
   logic             clr_cmd;
   logic [CNT_W-1:0] exec_ld;
   logic             init_act;
   logic             unused_bits;

   assign lcd_rw_o    = 1'b0;
   assign unused_bits = ^{io_lcd_i[29:10], io_lcd_i[8]};
   assign pending     = io_lcd_i[31] && (io_lcd_i[30] != ack_tgl_o);
   // Clear display (0x01) and return home (0x02/0x03) need the long wait
   assign clr_cmd     = !lcd_rs_o && (lcd_data_o[7:2] == 6'd0) && (lcd_data_o[1:0] != 2'd0);
   assign exec_ld     = clr_cmd ? CLR_LD : EXEC_LD;

`ifdef LCD_AUTO_INIT_EN
   localparam int PWR_W = (T_PWR_CYC > 1) ? $clog2(T_PWR_CYC) : 1;
   localparam logic [PWR_W-1:0] PWR_LD = PWR_W'(T_PWR_CYC - 1);

   logic [PWR_W-1:0] pwr_cnt;
   logic [1:0]       init_idx;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction
`else
   assign init_act = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
`ifdef LCD_AUTO_INIT_EN
         state    <= INIT_WAIT;
         pwr_cnt  <= PWR_LD;
         init_idx <= 2'd0;
         init_act <= 1'b1;
`else
         state    <= IDLE;
`endif
         cnt        <= '0;
         req        <= 1'b0;
         lcd_data_o <= 8'h00;
         lcd_rs_o   <= 1'b0;
         lcd_en_o   <= 1'b0;
         lcd_on_o   <= 1'b0;
         busy_o     <= 1'b0;
         ack_tgl_o  <= 1'b0;
      end else begin
         lcd_on_o <= io_lcd_i[31] | init_act;
         if (state != IDLE && !io_lcd_i[31] && !init_act) begin
            // Power dropped mid-write: discard the request by syncing ack to REQ
            state     <= IDLE;
            cnt       <= '0;
            lcd_en_o  <= 1'b0;
            busy_o    <= 1'b0;
            ack_tgl_o <= io_lcd_i[30];
         end else begin
            case (state)
               IDLE: begin
                  if (pending) begin
                     lcd_rs_o   <= io_lcd_i[9];
                     lcd_data_o <= io_lcd_i[7:0];
                     req        <= io_lcd_i[30];
                     busy_o     <= 1'b1;
                     cnt        <= SETUP_LD;
                     state      <= SETUP;
                  end
               end
               SETUP: begin
                  if (cnt == '0) begin
                     cnt      <= EN_LD;
                     lcd_en_o <= 1'b1;
                     state    <= PULSE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               PULSE: begin
                  if (cnt == '0) begin
                     cnt      <= HOLD_LD;
                     lcd_en_o <= 1'b0;
                     state    <= HOLD;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               HOLD: begin
                  if (cnt == '0) begin
                     cnt   <= exec_ld;
                     state <= EXEC;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               EXEC: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
`ifdef LCD_AUTO_INIT_EN
                  end else if (init_act && init_idx != 2'd3) begin
                     init_idx   <= init_idx + 2'd1;
                     lcd_data_o <= init_cmd(init_idx + 2'd1);
                     cnt        <= SETUP_LD;
                     state      <= SETUP;
                  end else if (init_act) begin
                     init_act <= 1'b0;
                     busy_o   <= 1'b0;
                     state    <= IDLE;
`endif
                  end else begin
                     ack_tgl_o <= req;
                     busy_o    <= 1'b0;
                     state     <= IDLE;
                  end
               end
`ifdef LCD_AUTO_INIT_EN
               INIT_WAIT: begin
                  busy_o <= 1'b1;
                  if (pwr_cnt == '0) begin
                     lcd_rs_o   <= 1'b0;
                     lcd_data_o <= init_cmd(2'd0);
                     cnt        <= SETUP_LD;
                     state      <= SETUP;
                  end else begin
                     pwr_cnt <= pwr_cnt - PWR_W'(1);
                  end
               end
`endif
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Bench for lcd_hd44780_driver: directed handshake scenarios plus random traffic
// compared every cycle against a timeline-based reference model.
module tb_lcd_hd44780_driver;
   localparam int TS = 2, TE = 3, TH = 1, TX = 5, TC = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] io = 32'h0;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ack;

   always #5 clk = ~clk;

   lcd_hd44780_driver #(
      .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
      .T_EXEC_CYC(TX), .T_CLR_CYC(TC), .CNT_W(17)
`ifdef LCD_AUTO_INIT_EN
      , .T_PWR_CYC(10)
`endif
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .io_lcd_i(io),
      .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
      .lcd_en_o(lcd_en), .lcd_on_o(lcd_on), .busy_o(busy), .ack_tgl_o(ack)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a transaction is a timeline measured from its accept edge.
   logic       m_busy = 0, m_ack = 0, m_rs = 0, m_en = 0, m_on = 0, m_req = 0;
   logic [7:0] m_data = 0;
   int         cyc = 0, m_start = 0, m_lat = 0, m_e = 0;
   logic       mon_en = 0;

   function automatic int exec_time(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'd1 && d <= 8'd3) ? TC : TX;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_busy = 0; m_ack = 0; m_rs = 0; m_en = 0; m_on = 0; m_req = 0; m_data = 0;
      end else begin
         m_on = io[31];
         if (m_busy) begin
            if (!io[31]) begin
               m_busy = 0; m_en = 0; m_ack = io[30];
            end else begin
               m_e = cyc - m_start;
               if (m_e == m_lat - 1) begin
                  m_busy = 0; m_en = 0; m_ack = m_req;
               end else begin
                  m_en = (m_e >= TS) && (m_e < TS + TE);
               end
            end
         end else if (io[31] && io[30] != m_ack) begin
            m_busy = 1; m_en = 0; m_rs = io[9]; m_data = io[7:0]; m_req = io[30];
            m_start = cyc;
            m_lat = 1 + TS + TE + TH + exec_time(io[9], io[7:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en)
         check("outputs", {18'd0, lcd_on, lcd_rs, lcd_data, lcd_en, busy, ack, lcd_rw},
               {18'd0, m_on, m_rs, m_data, m_en, m_busy, m_ack, 1'b0});
   end

   // Called at a negedge with the block idle; flips REQ and times the handshake.
   task automatic send_req(input logic rs, input logic [7:0] d, input int exp_lat);
      logic target;
      int   n, en_n;
      target = ~io[30];
      io[31] = 1'b1; io[30] = target; io[9] = rs; io[7:0] = d;
      n = 0; en_n = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (n == 1) check("busy_rise", busy, 1);
         if (lcd_en) en_n++;
         if (ack == target && !busy) break;
      end
      check("ack_latency", n, exp_lat);
      check("en_cycles", en_n, TE);
      check("rs_data_kept", {lcd_rs, lcd_data}, {rs, d});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(tag, busy, 0);
   endtask

`ifdef LCD_AUTO_INIT_EN
   initial begin
      logic [7:0] seen[$];
      logic       prev_en;
      int         n;
      repeat (3) @(negedge clk);
      check("rst_outs", {lcd_on, lcd_rs, lcd_data, lcd_en, busy, ack, lcd_rw}, 0);
      rst_n = 1;
      @(negedge clk);
      @(negedge clk);
      check("init_on_forced", lcd_on, 1);
      check("init_busy", busy, 1);
      prev_en = 0; n = 0;
      while (n < 2000 && (busy || n < 3)) begin
         if (lcd_en && !prev_en) seen.push_back(lcd_data);
         prev_en = lcd_en;
         @(negedge clk);
         n++;
      end
      check("init_done", busy, 0);
      check("init_pulses", seen.size(), 4);
      if (seen.size() == 4) begin
         check("init_cmd0", seen[0], 8'h38);
         check("init_cmd1", seen[1], 8'h0C);
         check("init_cmd2", seen[2], 8'h06);
         check("init_cmd3", seen[3], 8'h01);
      end
      check("init_ack", ack, 0);
      io = 32'h8000_0241;
      @(negedge clk);
      send_req(1'b1, 8'h41, 12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
`else
   initial begin
      int n, en_n;
      repeat (3) @(negedge clk);
      check("rst_outs", {lcd_on, lcd_rs, lcd_data, lcd_en, busy, ack, lcd_rw}, 0);
      rst_n = 1;
      mon_en = 1;
      io = 32'h8000_0241;
      @(negedge clk);
      @(negedge clk);
      check("on_latched", lcd_on, 1);

      send_req(1'b1, 8'h41, 12);
      send_req(1'b0, 8'h01, 27);
      send_req(1'b0, 8'h38, 12);
      send_req(1'b0, 8'h02, 27);
      send_req(1'b0, 8'h03, 27);
      send_req(1'b0, 8'h04, 12);
      send_req(1'b0, 8'h00, 12);
      send_req(1'b1, 8'h01, 12);

      // Even number of REQ flips while busy: nothing further happens.
      io[9] = 1; io[7:0] = 8'h41; io[30] = ~io[30];
      repeat (3) @(negedge clk);
      io[7:0] = 8'h55; io[30] = ~io[30];
      repeat (2) @(negedge clk);
      io[30] = ~io[30];
      wait_idle("even_done");
      repeat (5) @(negedge clk);
      check("even_no_txn", busy, 0);
      check("even_data", lcd_data, 8'h41);

      // Odd number: one more transaction with the new data right after IDLE.
      io[7:0] = 8'h41; io[30] = ~io[30];
      repeat (2) @(negedge clk);
      io[7:0] = 8'h55; io[30] = ~io[30];
      @(negedge clk); io[30] = ~io[30];
      @(negedge clk); io[30] = ~io[30];
      wait_idle("odd_first_done");
      check("odd_first_data", lcd_data, 8'h41);
      @(negedge clk);
      check("odd_second_busy", busy, 1);
      check("odd_second_data", lcd_data, 8'h55);
      wait_idle("odd_second_done");
      check("odd_ack", ack, io[30]);

      // Drop ON during the EN pulse.
      io[30] = ~io[30];
      n = 0;
      while (!lcd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("abort_in_pulse", lcd_en, 1);
      io[31] = 0;
      @(negedge clk);
      check("abort_en", lcd_en, 0);
      check("abort_busy", busy, 0);
      check("abort_ack", ack, io[30]);
      en_n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (lcd_en) en_n++;
      end
      check("abort_no_pulse", en_n, 0);

      // ON=0 in IDLE blocks acceptance until ON returns.
      io[30] = ~io[30];
      repeat (10) @(negedge clk);
      check("off_no_accept", busy, 0);
      io[31] = 1;
      @(negedge clk);
      @(negedge clk);
      check("on_accept", busy, 1);
      wait_idle("on_accept_done");

      // Reset in the middle of EXEC.
      io[30] = ~io[30];
      repeat (8) @(negedge clk);
      rst_n = 0;
      io[30] = 0;
      @(negedge clk);
      check("rst_mid_exec", {lcd_on, lcd_rs, lcd_data, lcd_en, busy, ack, lcd_rw}, 0);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) io[30] = ~io[30];
         if ($urandom_range(0, 7) == 0) begin
            io[9] = 1'($urandom_range(0, 1));
            io[7:0] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            io[29:10] = 20'($urandom);
         end
         io[31] = ($urandom_range(0, 59) != 0);
         rst_n = ($urandom_range(0, 599) != 0);
         @(negedge clk);
      end
      rst_n = 1;
      io[31] = 1;
      repeat (40) @(negedge clk);
      mon_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
`endif

endmodule
